// File: rtl/vo_frame_sequencer.sv
// Frame sequencer feeding the FAST/BRIEF raster pipeline: source handshake, feature cap, error reporting.
// Define VO_FRAME_STATS_EN to add frame cycle / dropped-feature statistics and double-start detection.
//   state  | meaning
//   IDLE   | waiting for request and pixel 0
//   STREAM | one pixel per cycle into the non-stallable pipeline
//   DRAIN  | source done, waiting for pipeline end (timed)
//   DONE   | one-cycle completion pulse
//   ERR    | sticky error until cleared
module vo_frame_sequencer #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int MAX_FEAT = 500,
    parameter int TIMEOUT  = 200000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_req,
    input  logic        i_err_clr,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_error,
    output logic [1:0]  o_err_code,
    output logic [7:0]  o_frame_id,
    output logic [9:0]  o_feat_count,
    input  logic [7:0]  i_src_pixel,
    input  logic        i_src_valid,
    output logic        o_src_ready,
    output logic [7:0]  o_pipe_pixel,
    output logic        o_pipe_start,
    input  logic        i_pipe_start,
    input  logic        i_pipe_flag,
    input  logic        i_pipe_end,
    output logic        o_feat_valid
`ifdef VO_FRAME_STATS_EN
    ,
    output logic [23:0] o_frame_cycles,
    output logic [9:0]  o_drop_count
`endif
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PIX_W = $clog2(NPIX + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
    localparam logic [9:0] FEAT_MAX = 10'(MAX_FEAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, next_state;

    logic [PIX_W-1:0] pix_cnt;
    logic [19:0]      to_cnt;
    logic             err_set;
    logic [1:0]       err_code_set;
    logic             accept;
    logic             stream_entry;
    logic             active;
    logic             dbl_start;

    assign active       = (state == S_STREAM) || (state == S_DRAIN);
    assign o_src_ready  = ((state == S_IDLE) && i_frame_req && !o_error) || (state == S_STREAM);
    assign accept       = o_src_ready && i_src_valid;
    assign stream_entry = (state == S_IDLE) && (next_state == S_STREAM);
    assign o_feat_valid = i_pipe_flag && (o_feat_count < FEAT_MAX) && active;

`ifdef VO_FRAME_STATS_EN
    logic        start_seen;
    logic [23:0] cyc_run;
    logic [24:0] cyc_total;

    assign dbl_start = active && i_pipe_start && start_seen;
    assign cyc_total = {1'b0, cyc_run} + 25'd2;
`else
    logic unused_pipe_start;

    assign unused_pipe_start = i_pipe_start;
    assign dbl_start = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        err_set      = 1'b0;
        err_code_set = 2'd0;
        case (state)
            S_IDLE: begin
                if (i_frame_req && i_src_valid && !o_error) begin
                    next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                // Underflow outranks everything: the pipeline has already lost a pixel slot.
                if (!i_src_valid) begin
                    next_state   = S_ERR;
                    err_set      = 1'b1;
                    err_code_set = 2'd1;
                end else if (i_pipe_end || dbl_start) begin
                    next_state   = S_ERR;
                    err_set      = 1'b1;
                    err_code_set = 2'd2;
                end else if (pix_cnt == PIX_LAST) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_pipe_end) begin
                    next_state = S_DONE;
                end else if (dbl_start) begin
                    next_state   = S_ERR;
                    err_set      = 1'b1;
                    err_code_set = 2'd2;
                end else if (to_cnt == TO_LAST) begin
                    next_state   = S_ERR;
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            S_ERR: begin
                if (i_err_clr) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= 2'd0;
            o_frame_id   <= 8'd0;
            o_feat_count <= 10'd0;
            o_pipe_pixel <= 8'd0;
            o_pipe_start <= 1'b0;
            pix_cnt      <= '0;
            to_cnt       <= 20'd0;
        end else begin
            state        <= next_state;
            o_busy       <= (next_state == S_STREAM) || (next_state == S_DRAIN);
            o_frame_done <= (next_state == S_DONE);
            o_pipe_start <= stream_entry;

            if (accept) begin
                o_pipe_pixel <= i_src_pixel;
            end

            if (stream_entry) begin
                pix_cnt <= PIX_W'(1);
            end else if ((state == S_STREAM) && accept) begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end

            if (state == S_DRAIN) begin
                to_cnt <= to_cnt + 20'd1;
            end else begin
                to_cnt <= 20'd0;
            end

            if (stream_entry) begin
                o_feat_count <= 10'd0;
            end else if (o_feat_valid) begin
                o_feat_count <= o_feat_count + 10'd1;
            end

            if ((state == S_DRAIN) && (next_state == S_DONE)) begin
                o_frame_id <= o_frame_id + 8'd1;
            end

            if (err_set) begin
                o_error    <= 1'b1;
                o_err_code <= err_code_set;
            end else if ((state == S_ERR) && i_err_clr) begin
                o_error    <= 1'b0;
                o_err_code <= 2'd0;
            end
        end
    end

`ifdef VO_FRAME_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_seen     <= 1'b0;
            cyc_run        <= 24'd0;
            o_frame_cycles <= 24'd0;
            o_drop_count   <= 10'd0;
        end else if (stream_entry) begin
            start_seen     <= 1'b0;
            cyc_run        <= 24'd0;
            o_frame_cycles <= 24'd0;
            o_drop_count   <= 10'd0;
        end else begin
            if (active && (cyc_run != 24'hFFFFFF)) begin
                cyc_run <= cyc_run + 24'd1;
            end
            // Total covers the current DRAIN cycle plus the DONE cycle.
            if ((state == S_DRAIN) && (next_state == S_DONE)) begin
                o_frame_cycles <= cyc_total[24] ? 24'hFFFFFF : cyc_total[23:0];
            end
            if (active && i_pipe_flag && !o_feat_valid && (o_drop_count != 10'h3FF)) begin
                o_drop_count <= o_drop_count + 10'd1;
            end
            if (active && i_pipe_start) begin
                start_seen <= 1'b1;
            end
        end
    end
`endif

endmodule
